ppu_hazard_forwarding_unit: RTL and testbench
=============================================

Name: ppu_hazard_forwarding_unit

Overview:
- Sequences the PPU pipeline around data hazards. It keeps a 3-entry scoreboard of in-flight register writes (EX, MEM, WB) built from the ID-stage decode outputs (RF enable, load flag, destination).
- It drives the ID-stage operand forwarding selects, the load-use stall, and the pipeline-register load enables.
- It sits beside the control unit and uses the same ID-stage signals.

Parameters:
- AW, 5, register address width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID slot holds a real instruction (0 = bubble).
- id_rs  input  AW  ID source register 1 (instr[25:21]).
- id_rt  input  AW  ID source register 2 (instr[20:16]).
- id_uses_rs  input  1  instruction reads rs.
- id_uses_rt  input  1  instruction reads rt.
- id_rf_enable  input  1  instruction writes the register file.
- id_load_instr  input  1  instruction is a load.
- id_dest  input  AW  destination register chosen in ID.
- fwd_a_sel  output  2  rs operand source: 00 RF, 01 EX result, 10 MEM result, 11 WB result.
- fwd_b_sel  output  2  rt operand source, same encoding.
- stall  output  1  load-use hazard this cycle.
- pc_le  output  1  PC load enable (= ~stall).
- if_id_le  output  1  IF/ID load enable (= ~stall).
- id_ex_bubble  output  1  force control signals into ID/EX to zero (= stall).
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
Scoreboard
- Entries EX, MEM, WB, each holding {v, we, ld, dst}.
- Every cycle: WB<=MEM, MEM<=EX.
- EX <= {id_valid & ~stall, id_rf_enable, id_load_instr, id_dest}. When stall=1, EX receives a bubble with v=0.
- An entry qualifies as a writer only when v & we & (dst != 0). Register 0 is never forwarded and never causes a stall.

Forwarding (combinational, same cycle as ID inputs)
- Per operand: if the operand is not used, select 00.
- Otherwise priority is EX, then MEM, then WB, then RF: choose the youngest qualifying entry whose dst equals the source.
- EX match with EX.ld=1: the select still reports 01, but stall is raised and the ID/EX capture is discarded.
- MEM or WB match on a load forwards normally; load data is valid at MEM output.

Stall
- stall = (EX qualifies & EX.ld) & ((id_uses_rs & EX.dst==id_rs) | (id_uses_rt & EX.dst==id_rt)) & id_valid.
- Exactly 1 cycle per load-use pair. The next cycle, the load is in MEM, so stall drops and fwd_sel = 10.
- Back-to-back loads each feeding the next instruction give one stall each; no stall chaining beyond that.

Counter
- stall_count increments by 1 on each cycle with stall=1.
- It holds at all-ones (no wrap).

Reset
- Synchronous; applies even mid-operation.
- All scoreboard entries v=0, stall_count=0.
- Outputs the cycle after reset: fwd_a_sel=00, fwd_b_sel=00, stall=0, pc_le=1, if_id_le=1, id_ex_bubble=0.
- While reset=1, stall is forced 0.

Simultaneous events
- Matches in both EX and MEM pick EX.
- rs==rt with both used gives identical selects.
- id_valid=0 never stalls, and it enters EX as a bubble.

Test Plan:
1. Reset, then ADDU r3 in ID (dest 3), then SUBU reading rs=3, rt=3 -> next cycle fwd_a_sel=01, fwd_b_sel=01, stall=0.
2. ADDU r3; NOP; NOP; SUBU rs=3 -> cycle of SUBU fwd_a_sel=11. With one NOP, fwd_a_sel=10.
3. LBU r5; then ADDIU rs=5 -> stall=1, pc_le=0, id_ex_bubble=1 for 1 cycle. Next cycle stall=0, fwd_a_sel=10, stall_count=1.
4. Writer with dest r0 followed by a reader of r0 -> fwd selects 00, stall 0.
5. Writers to r7 in MEM and EX, reader rt=7 -> fwd_b_sel=01. Reader with id_uses_rt=0 -> 00.
6. Assert reset during the stall cycle of scenario 3 -> next cycle stall=0, stall_count=0, selects 00. Also preload stall_count near all-ones and hold a stall -> counter saturates at 16'hFFFF.

Source files
------------

// File: rtl/ppu_hazard_forwarding_unit.sv
// PPU hazard unit: tracks in-flight register writes (EX/MEM/WB) and derives
// ID-stage operand forwarding selects, the load-use stall and pipeline enables.
module ppu_hazard_forwarding_unit #(
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_rf_enable,
  input  logic             id_load_instr,
  input  logic [AW-1:0]    id_dest,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             pc_le,
  output logic             if_id_le,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  logic          ex_v_q, ex_we_q, ex_ld_q;
  logic [AW-1:0] ex_dst_q;
  logic          mem_v_q, mem_we_q, mem_ld_q;
  logic [AW-1:0] mem_dst_q;
  logic          wb_v_q, wb_we_q;
  logic [AW-1:0] wb_dst_q;

  logic          ex_v_d, ex_we_d, ex_ld_d;
  logic [AW-1:0] ex_dst_d;
  logic          mem_v_d, mem_we_d, mem_ld_d;
  logic [AW-1:0] mem_dst_d;
  logic          wb_v_d, wb_we_d;
  logic [AW-1:0] wb_dst_d;

  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic ex_wr, mem_wr, wb_wr;
  logic rs_hits_ex, rt_hits_ex;

  // Register 0 is hard-wired, so writes to it never qualify as producers.
  always_comb begin
    ex_wr  = ex_v_q  & ex_we_q  & (ex_dst_q  != '0);
    mem_wr = mem_v_q & mem_we_q & (mem_dst_q != '0);
    wb_wr  = wb_v_q  & wb_we_q  & (wb_dst_q  != '0);
  end

  // Youngest qualifying producer wins; unused operands read the RF.
  always_comb begin
    fwd_a_sel = SEL_RF;
    if (id_uses_rs) begin
      if (ex_wr && (ex_dst_q == id_rs))        fwd_a_sel = SEL_EX;
      else if (mem_wr && (mem_dst_q == id_rs)) fwd_a_sel = SEL_MEM;
      else if (wb_wr && (wb_dst_q == id_rs))   fwd_a_sel = SEL_WB;
    end
  end

  always_comb begin
    fwd_b_sel = SEL_RF;
    if (id_uses_rt) begin
      if (ex_wr && (ex_dst_q == id_rt))        fwd_b_sel = SEL_EX;
      else if (mem_wr && (mem_dst_q == id_rt)) fwd_b_sel = SEL_MEM;
      else if (wb_wr && (wb_dst_q == id_rt))   fwd_b_sel = SEL_WB;
    end
  end

  // Load data is not ready until MEM, so a reader directly behind a load waits one cycle.
  always_comb begin
    rs_hits_ex   = id_uses_rs & (ex_dst_q == id_rs);
    rt_hits_ex   = id_uses_rt & (ex_dst_q == id_rt);
    stall        = ~reset & id_valid & ex_wr & ex_ld_q & (rs_hits_ex | rt_hits_ex);
    pc_le        = ~stall;
    if_id_le     = ~stall;
    id_ex_bubble = stall;
    stall_count  = stall_count_q;
  end

  always_comb begin
    ex_v_d    = id_valid & ~stall;
    ex_we_d   = id_rf_enable;
    ex_ld_d   = id_load_instr;
    ex_dst_d  = id_dest;
    mem_v_d   = ex_v_q;
    mem_we_d  = ex_we_q;
    mem_ld_d  = ex_ld_q;
    mem_dst_d = ex_dst_q;
    wb_v_d    = mem_v_q;
    wb_we_d   = mem_we_q;
    wb_dst_d  = mem_dst_q;
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v_q        <= 1'b0;
      ex_we_q       <= 1'b0;
      ex_ld_q       <= 1'b0;
      ex_dst_q      <= '0;
      mem_v_q       <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_ld_q      <= 1'b0;
      mem_dst_q     <= '0;
      wb_v_q        <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_dst_q      <= '0;
      stall_count_q <= '0;
    end else begin
      ex_v_q        <= ex_v_d;
      ex_we_q       <= ex_we_d;
      ex_ld_q       <= ex_ld_d;
      ex_dst_q      <= ex_dst_d;
      mem_v_q       <= mem_v_d;
      mem_we_q      <= mem_we_d;
      mem_ld_q      <= mem_ld_d;
      mem_dst_q     <= mem_dst_d;
      wb_v_q        <= wb_v_d;
      wb_we_q       <= wb_we_d;
      wb_dst_q      <= wb_dst_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Load flag is only consulted in EX; MEM copy is kept for pipeline symmetry.
  logic unused_ok;
  assign unused_ok = mem_ld_q;

endmodule

// File: tb/tb_ppu_hazard_forwarding_unit.sv
// Directed bench for ppu_hazard_forwarding_unit: forwarding priority, load-use
// stall, r0 handling, reset mid-stall and counter saturation (4-bit instance).
module tb_ppu_hazard_forwarding_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_rf_enable, id_load_instr;

  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall, pc_le, if_id_le, id_ex_bubble;
  logic [15:0] stall_count;

  logic [1:0] s_fwd_a_sel, s_fwd_b_sel;
  logic       s_stall, s_pc_le, s_if_id_le, s_id_ex_bubble;
  logic [3:0] s_stall_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ppu_hazard_forwarding_unit #(.AW(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rf_enable(id_rf_enable),
    .id_load_instr(id_load_instr), .id_dest(id_dest),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .pc_le(pc_le),
    .if_id_le(if_id_le), .id_ex_bubble(id_ex_bubble), .stall_count(stall_count)
  );

  ppu_hazard_forwarding_unit #(.AW(5), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rf_enable(id_rf_enable),
    .id_load_instr(id_load_instr), .id_dest(id_dest),
    .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel), .stall(s_stall), .pc_le(s_pc_le),
    .if_id_le(s_if_id_le), .id_ex_bubble(s_id_ex_bubble), .stall_count(s_stall_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present one ID-stage instruction and let the combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic we,
                       input logic ld, input logic [4:0] dst);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_rf_enable = we; id_load_instr = ld; id_dest = dst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic flush();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;
    idle();
    check("rst_fwd_a", 32'(fwd_a_sel), 32'h0);
    check("rst_fwd_b", 32'(fwd_b_sel), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_pc_le", 32'(pc_le), 32'h1);
    check("rst_if_id_le", 32'(if_id_le), 32'h1);
    check("rst_bubble", 32'(id_ex_bubble), 32'h0);
    check("rst_count", 32'(stall_count), 32'h0);

    // ADDU r3 then SUBU r3,r3 -> both from EX
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    tick();
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
    check("ex_fwd_a", 32'(fwd_a_sel), 32'h1);
    check("ex_fwd_b", 32'(fwd_b_sel), 32'h1);
    check("ex_no_stall", 32'(stall), 32'h0);

    // two NOPs -> WB; one NOP -> MEM
    flush();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    tick(); idle(); tick(); idle(); tick();
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4);
    check("wb_fwd_a", 32'(fwd_a_sel), 32'h3);
    flush();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    tick(); idle(); tick();
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4);
    check("mem_fwd_a", 32'(fwd_a_sel), 32'h2);

    // load-use: LBU r5; ADDIU rs=5
    flush();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
    tick();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6);
    check("lu_stall", 32'(stall), 32'h1);
    check("lu_pc_le", 32'(pc_le), 32'h0);
    check("lu_if_id_le", 32'(if_id_le), 32'h0);
    check("lu_bubble", 32'(id_ex_bubble), 32'h1);
    check("lu_fwd_a_ex", 32'(fwd_a_sel), 32'h1);
    tick();
    check("lu_stall_drop", 32'(stall), 32'h0);
    check("lu_fwd_a_mem", 32'(fwd_a_sel), 32'h2);
    check("lu_count1", 32'(stall_count), 32'h1);

    // back-to-back loads: one stall each
    flush();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
    tick();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
    check("bb_stall1", 32'(stall), 32'h1);
    tick();
    check("bb_stall1_drop", 32'(stall), 32'h0);
    tick();
    drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7);
    check("bb_stall2", 32'(stall), 32'h1);
    tick();
    check("bb_stall2_drop", 32'(stall), 32'h0);
    check("bb_fwd_a_mem", 32'(fwd_a_sel), 32'h2);
    check("bb_count3", 32'(stall_count), 32'h3);

    // r0 producers (including a load) never forward or stall
    flush();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
    check("r0_fwd_a", 32'(fwd_a_sel), 32'h0);
    check("r0_fwd_b", 32'(fwd_b_sel), 32'h0);
    check("r0_stall", 32'(stall), 32'h0);

    // r7 in MEM and EX -> EX wins; unused rt -> RF
    flush();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
    tick();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
    tick();
    drive(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9);
    check("pri_fwd_b_ex", 32'(fwd_b_sel), 32'h1);
    check("pri_fwd_a_rf", 32'(fwd_a_sel), 32'h0);
    drive(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9);
    check("unused_rt", 32'(fwd_b_sel), 32'h0);

    // invalid ID slot never stalls
    flush();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
    tick();
    drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6);
    check("bubble_no_stall", 32'(stall), 32'h0);

    // reset during a stall cycle
    flush();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
    tick();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6);
    check("mid_stall", 32'(stall), 32'h1);
    reset = 1'b1;
    #1;
    check("rst_forces_stall0", 32'(stall), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_stall", 32'(stall), 32'h0);
    check("post_rst_count", 32'(stall_count), 32'h0);
    check("post_rst_fwd_a", 32'(fwd_a_sel), 32'h0);
    check("post_rst_fwd_b", 32'(fwd_b_sel), 32'h0);

    // 17 load-use stalls: 4-bit counter saturates at F, 16-bit reaches 17
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
      tick();
      drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6);
      if (i == 16) check("sat_stall_active", 32'(s_stall), 32'h1);
      tick();
    end
    check("sat_count_hold", 32'(s_stall_count), 32'hF);
    check("wide_count_17", 32'(stall_count), 32'd17);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
